// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared defines for the pipeline hazard controller
//
// Purpose: FSM state encodings and default widths shared by hazard_ctrl
// and anything that decodes its StateOut.
package hazard_ctrl_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_MDWAIT  = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/bubble controller
//
// Purpose: resolves data-memory waits, multi-cycle unit waits, taken
// branches and EX->ID data dependencies into per-stage stall, flush and
// bubble controls, and counts stalled cycles.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   Rs{1,2}AddrIdIn/ReadEnableIdIn  sources of the instruction in ID
//   RdAddrExIn/RdWriteEnableExIn    destination of the instruction in EX
//   MemReadExIn                     EX instruction is a load
//   MulDivBusyExIn/MulDivDoneIn     multi-cycle unit status in EX
//   MemReqMemIn/MemReadyMemIn       data-memory access status in MEM
//   BranchTakenExIn                 redirect resolved in EX
//   Stall{If,Id,Ex,Mem}Out          hold PC / pipeline registers
//   FlushIdOut, Bubble{Ex,Mem,Wb}Out insert NOPs
//   StateOut, StallCntOut           FSM state, saturating stall counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1AddrIdIn,
  input  logic [REG_AW-1:0] Rs2AddrIdIn,
  input  logic              Rs1ReadEnableIdIn,
  input  logic              Rs2ReadEnableIdIn,
  input  logic [REG_AW-1:0] RdAddrExIn,
  input  logic              RdWriteEnableExIn,
  input  logic              MemReadExIn,
  input  logic              MulDivBusyExIn,
  input  logic              MulDivDoneIn,
  input  logic              MemReqMemIn,
  input  logic              MemReadyMemIn,
  input  logic              BranchTakenExIn,
  output logic              StallIfOut,
  output logic              StallIdOut,
  output logic              StallExOut,
  output logic              StallMemOut,
  output logic              FlushIdOut,
  output logic              BubbleExOut,
  output logic              BubbleMemOut,
  output logic              BubbleWbOut,
  output logic [1:0]        StateOut,
  output logic [CNT_W-1:0]  StallCntOut
);

  hz_state_e          state_q, state_d;
  // Set while in MEMWAIT when the wait interrupted a pending load-use bubble.
  logic               ldu_ret_q, ldu_ret_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic dep;
  logic mem_wait;
  logic md_wait;

  // Only EX/MEM and MEM/WB are forwarded, so an EX producer always stalls.
  // x0 is hard-wired zero and never creates a dependency.
  assign dep = RdWriteEnableExIn && (RdAddrExIn != '0) &&
               ((Rs1ReadEnableIdIn && (Rs1AddrIdIn == RdAddrExIn)) ||
                (Rs2ReadEnableIdIn && (Rs2AddrIdIn == RdAddrExIn)));

  assign mem_wait = MemReqMemIn && !MemReadyMemIn;
  assign md_wait  = MulDivBusyExIn && !MulDivDoneIn;

  always_comb begin
    StallIfOut   = 1'b0;
    StallIdOut   = 1'b0;
    StallExOut   = 1'b0;
    StallMemOut  = 1'b0;
    FlushIdOut   = 1'b0;
    BubbleExOut  = 1'b0;
    BubbleMemOut = 1'b0;
    BubbleWbOut  = 1'b0;
    state_d      = ST_RUN;
    ldu_ret_d    = 1'b0;

    if (mem_wait) begin
      StallIfOut  = 1'b1;
      StallIdOut  = 1'b1;
      StallExOut  = 1'b1;
      StallMemOut = 1'b1;
      BubbleWbOut = 1'b1;
      state_d     = ST_MEMWAIT;
      ldu_ret_d   = (state_q == ST_LDUSE) || ((state_q == ST_MEMWAIT) && ldu_ret_q);
    end else if (md_wait) begin
      StallIfOut   = 1'b1;
      StallIdOut   = 1'b1;
      StallExOut   = 1'b1;
      BubbleMemOut = 1'b1;
      state_d      = ST_MDWAIT;
    end else if (BranchTakenExIn) begin
      // Redirect kills the wrong-path ID instruction, so a pending
      // load-use bubble is no longer needed.
      FlushIdOut  = 1'b1;
      BubbleExOut = 1'b1;
      state_d     = ST_RUN;
    end else begin
      case (state_q)
        ST_LDUSE: begin
          StallIfOut  = 1'b1;
          StallIdOut  = 1'b1;
          BubbleExOut = 1'b1;
          state_d     = ST_RUN;
        end
        ST_MEMWAIT: begin
          if (ldu_ret_q) begin
            // Resume the interrupted load-use: its second bubble comes next.
            state_d = ST_LDUSE;
          end else if (dep) begin
            StallIfOut  = 1'b1;
            StallIdOut  = 1'b1;
            BubbleExOut = 1'b1;
            state_d     = MemReadExIn ? ST_LDUSE : ST_RUN;
          end
        end
        default: begin
          if (dep) begin
            StallIfOut  = 1'b1;
            StallIdOut  = 1'b1;
            BubbleExOut = 1'b1;
            state_d     = MemReadExIn ? ST_LDUSE : ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallIfOut && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ldu_ret_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ldu_ret_q   <= ldu_ret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StateOut    = state_q;
  assign StallCntOut = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] Rs1AddrIdIn, Rs2AddrIdIn, RdAddrExIn;
  logic              Rs1ReadEnableIdIn, Rs2ReadEnableIdIn;
  logic              RdWriteEnableExIn, MemReadExIn;
  logic              MulDivBusyExIn, MulDivDoneIn;
  logic              MemReqMemIn, MemReadyMemIn, BranchTakenExIn;
  logic              StallIfOut, StallIdOut, StallExOut, StallMemOut;
  logic              FlushIdOut, BubbleExOut, BubbleMemOut, BubbleWbOut;
  logic [1:0]        StateOut;
  logic [CNT_W-1:0]  StallCntOut;
  logic [7:0]        outs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {StallIf, StallId, StallEx, StallMem, FlushId, BubbleEx, BubbleMem, BubbleWb}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_DEP  = 8'b1100_0100;
  localparam logic [7:0] O_MEM  = 8'b1111_0001;
  localparam logic [7:0] O_MD   = 8'b1110_0010;
  localparam logic [7:0] O_BR   = 8'b0000_1100;

  assign outs = {StallIfOut, StallIdOut, StallExOut, StallMemOut,
                 FlushIdOut, BubbleExOut, BubbleMemOut, BubbleWbOut};

  hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1AddrIdIn(Rs1AddrIdIn), .Rs2AddrIdIn(Rs2AddrIdIn),
    .Rs1ReadEnableIdIn(Rs1ReadEnableIdIn), .Rs2ReadEnableIdIn(Rs2ReadEnableIdIn),
    .RdAddrExIn(RdAddrExIn), .RdWriteEnableExIn(RdWriteEnableExIn),
    .MemReadExIn(MemReadExIn),
    .MulDivBusyExIn(MulDivBusyExIn), .MulDivDoneIn(MulDivDoneIn),
    .MemReqMemIn(MemReqMemIn), .MemReadyMemIn(MemReadyMemIn),
    .BranchTakenExIn(BranchTakenExIn),
    .StallIfOut(StallIfOut), .StallIdOut(StallIdOut),
    .StallExOut(StallExOut), .StallMemOut(StallMemOut),
    .FlushIdOut(FlushIdOut), .BubbleExOut(BubbleExOut),
    .BubbleMemOut(BubbleMemOut), .BubbleWbOut(BubbleWbOut),
    .StateOut(StateOut), .StallCntOut(StallCntOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [REG_AW-1:0] rs1;
    logic             rs1_en;
    logic [REG_AW-1:0] rs2;
    logic             rs2_en;
    logic [REG_AW-1:0] rd;
    logic             rd_we;
    logic             mem_rd;
    logic             md_busy;
    logic             md_done;
    logic             mem_req;
    logic             mem_rdy;
    logic             br;
    logic [7:0]       exp_outs;
    logic [1:0]       exp_st;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, int rs1, bit rs1_en, int rs2, bit rs2_en,
                              int rd, bit rd_we, bit mem_rd, bit md_busy, bit md_done,
                              bit mem_req, bit mem_rdy, bit br,
                              logic [7:0] exp_outs, int exp_st);
    vec_t v;
    v.name = name;
    v.rs1 = REG_AW'(rs1); v.rs1_en = rs1_en;
    v.rs2 = REG_AW'(rs2); v.rs2_en = rs2_en;
    v.rd = REG_AW'(rd); v.rd_we = rd_we; v.mem_rd = mem_rd;
    v.md_busy = md_busy; v.md_done = md_done;
    v.mem_req = mem_req; v.mem_rdy = mem_rdy; v.br = br;
    v.exp_outs = exp_outs; v.exp_st = 2'(exp_st);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    Rs1AddrIdIn = '0; Rs2AddrIdIn = '0; RdAddrExIn = '0;
    Rs1ReadEnableIdIn = 0; Rs2ReadEnableIdIn = 0;
    RdWriteEnableExIn = 0; MemReadExIn = 0;
    MulDivBusyExIn = 0; MulDivDoneIn = 0;
    MemReqMemIn = 0; MemReadyMemIn = 0; BranchTakenExIn = 0;
  endtask

  task automatic apply(vec_t v);
    Rs1AddrIdIn = v.rs1; Rs1ReadEnableIdIn = v.rs1_en;
    Rs2AddrIdIn = v.rs2; Rs2ReadEnableIdIn = v.rs2_en;
    RdAddrExIn = v.rd; RdWriteEnableExIn = v.rd_we; MemReadExIn = v.mem_rd;
    MulDivBusyExIn = v.md_busy; MulDivDoneIn = v.md_done;
    MemReqMemIn = v.mem_req; MemReadyMemIn = v.mem_rdy;
    BranchTakenExIn = v.br;
  endtask

  // Called 1 time unit after a rising edge; releases reset well before the next one.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load-use with EX and ID inputs set to: EX load x7, ID reads rs2=x7.
  task automatic set_load_use();
    idle();
    RdAddrExIn = 5'd7; RdWriteEnableExIn = 1; MemReadExIn = 1;
    Rs2AddrIdIn = 5'd7; Rs2ReadEnableIdIn = 1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_state", 32'(StateOut), 32'd0);
    chk("reset_cnt", 32'(StallCntOut), 32'd0);
    chk("reset_outs", 32'(outs), 32'(O_NONE));
    tick();
    rst_n = 1'b1;

    //            name           rs1 en rs2 en rd we ld mb md mq mr br  outs    st
    vecs[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vecs[1]  = mk("add_x5_rs1",    5, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_DEP,  0);
    vecs[2]  = mk("load_x7_rs2",   1, 1, 7, 1, 7, 1, 1, 0, 0, 0, 0, 0, O_DEP,  1);
    vecs[3]  = mk("load_x0",       0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE, 0);
    vecs[4]  = mk("rs1_not_read",  5, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vecs[5]  = mk("rd_no_write",   5, 1, 5, 1, 5, 0, 1, 0, 0, 0, 0, 0, O_NONE, 0);
    vecs[6]  = mk("rs2_not_read",  3, 1, 9, 0, 9, 1, 1, 0, 0, 0, 0, 0, O_NONE, 0);
    vecs[7]  = mk("mem_wait",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MEM,  2);
    vecs[8]  = mk("mem_ready",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_NONE, 0);
    vecs[9]  = mk("md_wait",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_MD,   3);
    vecs[10] = mk("md_done",       0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, O_NONE, 0);
    vecs[11] = mk("br_over_ldu",   7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, O_BR,   0);
    vecs[12] = mk("mem_over_all",  7, 1, 0, 0, 7, 1, 1, 1, 0, 1, 0, 1, O_MEM,  2);
    vecs[13] = mk("md_over_br",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, O_MD,   3);
    vecs[14] = mk("branch",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BR,   0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_outs"}, 32'(outs), 32'(vecs[i].exp_outs));
      tick();
      chk({vecs[i].name, "_state"}, 32'(StateOut), 32'(vecs[i].exp_st));
      chk({vecs[i].name, "_cnt"}, 32'(StallCntOut), vecs[i].exp_outs[7] ? 32'd1 : 32'd0);
    end

    // Load-use: two consecutive bubbles, state 0 -> 1 -> 0, counter +2.
    do_reset();
    set_load_use();
    #1;
    chk("ldu_c1_outs", 32'(outs), 32'(O_DEP));
    tick();
    chk("ldu_c1_state", 32'(StateOut), 32'd1);
    idle();
    Rs2AddrIdIn = 5'd7; Rs2ReadEnableIdIn = 1;  // EX now holds the bubble
    #1;
    chk("ldu_c2_outs", 32'(outs), 32'(O_DEP));
    tick();
    chk("ldu_c2_state", 32'(StateOut), 32'd0);
    chk("ldu_cnt", 32'(StallCntOut), 32'd2);
    idle();
    #1;
    chk("ldu_after_outs", 32'(outs), 32'(O_NONE));

    // Memory wait for three cycles, then ready.
    do_reset();
    MemReqMemIn = 1; MemReadyMemIn = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("memw_c%0d_outs", c), 32'(outs), 32'(O_MEM));
      tick();
      chk($sformatf("memw_c%0d_state", c), 32'(StateOut), 32'd2);
    end
    MemReadyMemIn = 1;
    #1;
    chk("memw_ready_outs", 32'(outs), 32'(O_NONE));
    tick();
    chk("memw_ready_state", 32'(StateOut), 32'd0);
    chk("memw_cnt", 32'(StallCntOut), 32'd3);

    // Memory wait arriving during LDUSE resumes the load-use afterwards.
    do_reset();
    set_load_use();
    tick();
    chk("ldmw_state_ldu", 32'(StateOut), 32'd1);
    idle();
    MemReqMemIn = 1;
    #1;
    chk("ldmw_wait_outs", 32'(outs), 32'(O_MEM));
    tick();
    chk("ldmw_state_mw", 32'(StateOut), 32'd2);
    MemReadyMemIn = 1;
    #1;
    chk("ldmw_ready_outs", 32'(outs), 32'(O_NONE));
    tick();
    chk("ldmw_state_back", 32'(StateOut), 32'd1);
    idle();
    #1;
    chk("ldmw_bubble_outs", 32'(outs), 32'(O_DEP));
    tick();
    chk("ldmw_state_run", 32'(StateOut), 32'd0);
    chk("ldmw_cnt", 32'(StallCntOut), 32'd3);

    // Branch held by a multi-cycle wait is honoured on the done cycle.
    do_reset();
    MulDivBusyExIn = 1; BranchTakenExIn = 1;
    tick();
    chk("mdbr_state", 32'(StateOut), 32'd3);
    MulDivDoneIn = 1;
    #1;
    chk("mdbr_exit_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("mdbr_exit_state", 32'(StateOut), 32'd0);

    // Counter saturates at all-ones.
    do_reset();
    MemReqMemIn = 1;
    for (int c = 0; c < 15; c++) tick();
    chk("sat_at_max", 32'(StallCntOut), 32'd15);
    for (int c = 0; c < 5; c++) tick();
    chk("sat_no_wrap", 32'(StallCntOut), 32'd15);

    // Asynchronous reset in the middle of MDWAIT.
    do_reset();
    MulDivBusyExIn = 1;
    tick();
    chk("mdrst_state_pre", 32'(StateOut), 32'd3);
    chk("mdrst_cnt_pre", 32'(StallCntOut), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mdrst_state", 32'(StateOut), 32'd0);
    chk("mdrst_cnt", 32'(StallCntOut), 32'd0);
    idle();
    #1;
    chk("mdrst_outs", 32'(outs), 32'(O_NONE));
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
